// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared widths, default parameters and beat/pipe record types for the AES decrypt stream wrapper
package aes_dec_pkg;
   localparam int BLOCK_W = 128;
   localparam int KEY_W = 128;
   localparam int TAG_W = 8;
   localparam int DEF_NUM_KEYS = 27;
   localparam int DEF_CORE_LATENCY = 20;
   localparam int DEF_FIFO_DEPTH = 32;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic err;
      logic [BLOCK_W-1:0] data;
   } beat_t;
   typedef struct packed {
      logic vld;
      logic [TAG_W-1:0] tag;
      logic err;
   } pipe_t;
endpackage

// File: rtl/aes_dec_stream_ctrl_if.sv
// aes_dec_stream_ctrl_if: ciphertext input (s_*) and plaintext output (m_*) valid/ready bus; slave = wrapper side, master = source/consumer side
interface aes_dec_stream_ctrl_if #(parameter int KIDX_W = $clog2(aes_dec_pkg::DEF_NUM_KEYS));
   import aes_dec_pkg::*;
   logic s_valid;
   logic s_ready;
   logic [BLOCK_W-1:0] s_data;
   logic [KIDX_W-1:0] s_key_idx;
   logic [TAG_W-1:0] s_tag;
   logic m_valid;
   logic m_ready;
   logic [BLOCK_W-1:0] m_data;
   logic [TAG_W-1:0] m_tag;
   logic m_err;
   modport master (output s_valid, s_data, s_key_idx, s_tag, m_ready, input s_ready, m_valid, m_data, m_tag, m_err);
   modport slave (input s_valid, s_data, s_key_idx, s_tag, m_ready, output s_ready, m_valid, m_data, m_tag, m_err);
endinterface

// File: rtl/aes_dec_out_fifo.sv
// aes_dec_out_fifo: synchronous beat FIFO, no fall-through (ports: clk/rst, push/din, pop/dout, count/full/empty)
module aes_dec_out_fifo
   import aes_dec_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  beat_t din,
   input  logic pop,
   output beat_t dout,
   output logic [AW:0] count,
   output logic full,
   output logic empty
);
   beat_t mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic do_pop;
   assign do_pop = pop && !empty;
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= din;
   assign count = count_q;
   assign full = count_q == (AW+1)'(DEPTH);
   assign empty = count_q == '0;
   assign dout = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/aes_dec_stream_ctrl.sv
// aes_dec_stream_ctrl: flow-control wrapper around a fixed-latency AES-128 decrypt core (ports: clk/rst, key_wr_* table write, bus stream slave, core_ct/core_key/core_pt, in_flight, err_bad_key)
module aes_dec_stream_ctrl
   import aes_dec_pkg::*;
#(
   parameter int NUM_KEYS = DEF_NUM_KEYS,
   parameter int CORE_LATENCY = DEF_CORE_LATENCY,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int KIDX_W = $clog2(NUM_KEYS),
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_wr_en,
   input  logic [KIDX_W-1:0] key_wr_idx,
   input  logic [KEY_W-1:0] key_wr_data,
   aes_dec_stream_ctrl_if.slave bus,
   output logic [BLOCK_W-1:0] core_ct,
   output logic [KEY_W-1:0] core_key,
   input  logic [BLOCK_W-1:0] core_pt,
   output logic [CNT_W-1:0] in_flight,
   output logic err_bad_key
);
   logic [KEY_W-1:0] key_tbl_q [NUM_KEYS];
   logic [KEY_W-1:0] key_tbl_d [NUM_KEYS];
   logic [BLOCK_W-1:0] core_ct_q, core_ct_d;
   logic [KEY_W-1:0] core_key_q, core_key_d;
   pipe_t pipe_q [CORE_LATENCY];
   pipe_t pipe_d [CORE_LATENCY];
   logic [CNT_W-1:0] in_flight_q, in_flight_d, fifo_count;
   logic err_bad_key_q, err_bad_key_d;
   logic accept, bad_idx, push, pop, fifo_full, fifo_empty;
   pipe_t pipe_exit;
   beat_t push_beat, pop_beat;
   // every accepted block reserves a FIFO slot, so occupancy counts blocks still inside the core
   assign bus.s_ready = !rst && ({1'b0, in_flight_q} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
   assign accept = bus.s_valid && bus.s_ready;
   assign bad_idx = int'(bus.s_key_idx) >= NUM_KEYS;
   assign pipe_exit = pipe_q[CORE_LATENCY-1];
   assign push = pipe_exit.vld;
   assign pop = bus.m_valid && bus.m_ready;
   always_comb begin
      key_tbl_d = key_tbl_q;
      if (key_wr_en && int'(key_wr_idx) < NUM_KEYS) key_tbl_d[key_wr_idx] = key_wr_data;
      core_ct_d = accept ? bus.s_data : '0;
      core_key_d = (accept && !bad_idx) ? key_tbl_q[bus.s_key_idx] : '0;
      pipe_d[0] = '{vld: accept, tag: accept ? bus.s_tag : '0, err: accept && bad_idx};
      for (int i = 1; i < CORE_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(push);
      err_bad_key_d = err_bad_key_q || (accept && bad_idx);
      // the core output is meaningless for a bad-key block, so it is masked here
      push_beat = '{tag: pipe_exit.tag, err: pipe_exit.err, data: pipe_exit.err ? '0 : core_pt};
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         key_tbl_q <= '{default: '0};
         core_ct_q <= '0;
         core_key_q <= '0;
         pipe_q <= '{default: '0};
         in_flight_q <= '0;
         err_bad_key_q <= 1'b0;
      end else begin
         key_tbl_q <= key_tbl_d;
         core_ct_q <= core_ct_d;
         core_key_q <= core_key_d;
         pipe_q <= pipe_d;
         in_flight_q <= in_flight_d;
         err_bad_key_q <= err_bad_key_d;
      end
   aes_dec_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .din(push_beat),
      .pop(pop),
      .dout(pop_beat),
      .count(fifo_count),
      .full(fifo_full),
      .empty(fifo_empty)
   );
   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
   assign bus.m_valid = !fifo_empty;
   assign bus.m_data = pop_beat.data;
   assign bus.m_tag = pop_beat.tag;
   assign bus.m_err = pop_beat.err;
   assign core_ct = core_ct_q;
   assign core_key = core_key_q;
   assign in_flight = in_flight_q;
   assign err_bad_key = err_bad_key_q;
endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// tb_aes_dec_stream_ctrl: scoreboard bench for aes_dec_stream_ctrl with an XOR stand-in core of matching latency
module tb_aes_dec_stream_ctrl;
   import aes_dec_pkg::*;
   localparam int NK = 27;
   localparam int L = 20;
   localparam int FD = 32;
   localparam int KW = 5;
   localparam logic [127:0] K3 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] K5 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K5B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K26 = 128'hffeeddccbbaa99887766554433221100;
   typedef struct {
      logic [127:0] ct;
      logic [KW-1:0] kidx;
      logic [7:0] tag;
      logic [127:0] exp_data;
      logic exp_err;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_wr_en = 1'b0;
   logic [KW-1:0] key_wr_idx = '0;
   logic [127:0] key_wr_data = '0;
   logic [127:0] core_ct, core_key, core_pt;
   logic [5:0] in_flight;
   logic err_bad_key;
   logic [127:0] core_pipe [L-1];
   logic [127:0] keys [NK];
   beat_t sb [$];
   beat_t mon_exp;
   vec_t vecs [27];
   logic [127:0] ct2 [40];
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int first_acc_cyc = -1;
   int first_mv_cyc = -1;
   aes_dec_stream_ctrl_if #(.KIDX_W(KW)) bus ();
   aes_dec_stream_ctrl #(.NUM_KEYS(NK), .CORE_LATENCY(L), .FIFO_DEPTH(FD)) dut (
      .clk(clk),
      .rst(rst),
      .key_wr_en(key_wr_en),
      .key_wr_idx(key_wr_idx),
      .key_wr_data(key_wr_data),
      .bus(bus),
      .core_ct(core_ct),
      .core_key(core_key),
      .core_pt(core_pt),
      .in_flight(in_flight),
      .err_bad_key(err_bad_key)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      core_pipe[0] <= core_ct ^ core_key;
      for (int i = 1; i < L - 1; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_pt = core_pipe[L-2];
   always @(negedge clk)
      if (!rst && bus.m_valid) begin
         if (first_mv_cyc < 0) first_mv_cyc = cyc;
         if (bus.m_ready) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_beat: got tag %h err %b data %h, required no beat", bus.m_tag, bus.m_err, bus.m_data);
            end else begin
               mon_exp = sb.pop_front();
               if ({bus.m_tag, bus.m_err, bus.m_data} !== mon_exp) begin
                  fails++;
                  $display("FAIL beat: got tag %h err %b data %h, required tag %h err %b data %h", bus.m_tag, bus.m_err, bus.m_data, mon_exp.tag, mon_exp.err, mon_exp.data);
               end
            end
         end
      end
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask
   function automatic beat_t model(input logic [127:0] ct, input logic [KW-1:0] k, input logic [7:0] t);
      logic bad;
      bad = int'(k) >= NK;
      return '{tag: t, err: bad, data: bad ? '0 : ct ^ keys[k]};
   endfunction
   task automatic step(input logic v, input logic [127:0] ct, input logic [KW-1:0] k, input logic [7:0] t, input logic mr, input beat_t exp, output logic acc);
      bus.s_valid = v;
      bus.s_data = ct;
      bus.s_key_idx = k;
      bus.s_tag = t;
      bus.m_ready = mr;
      acc = v && bus.s_ready;
      if (acc) begin
         sb.push_back(exp);
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (key_wr_en && int'(key_wr_idx) < NK) keys[key_wr_idx] = key_wr_data;
      key_wr_en = 1'b0;
   endtask
   task automatic send(input logic v, input logic [127:0] ct, input logic [KW-1:0] k, input logic [7:0] t, input logic mr, output logic acc);
      step(v, ct, k, t, mr, model(ct, k, t), acc);
   endtask
   task automatic idle(input logic mr);
      logic a;
      step(1'b0, '0, '0, '0, mr, '0, a);
   endtask
   task automatic wr_key(input logic [KW-1:0] idx, input logic [127:0] data);
      key_wr_en = 1'b1;
      key_wr_idx = idx;
      key_wr_data = data;
      idle(1'b1);
   endtask
   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((sb.size() != 0 || in_flight != 0) && n < 300) begin
         idle(1'b1);
         n++;
      end
      chk(nm, 128'(sb.size()), 0);
   endtask
   initial begin
      logic a;
      int nacc, mv;
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.s_key_idx = '0;
      bus.s_tag = '0;
      bus.m_ready = 1'b0;
      keys = '{default: '0};
      for (int i = 0; i < 24; i++) begin
         vecs[i].ct = {4{32'(32'h9e3779b9 * (i + 1))}};
         vecs[i].kidx = 5;
         vecs[i].tag = 8'(i);
         vecs[i].exp_data = vecs[i].ct ^ K5;
         vecs[i].exp_err = 1'b0;
      end
      vecs[24] = '{128'h0123456789abcdeffedcba9876543210, 5'd30, 8'hA5, 128'h0, 1'b1};
      vecs[25] = '{128'h55aa55aa55aa55aa55aa55aa55aa55aa, 5'd27, 8'h27, 128'h0, 1'b1};
      vecs[26] = '{128'hdeadbeefcafef00d0badc0de12345678, 5'd26, 8'h26, 128'hdeadbeefcafef00d0badc0de12345678 ^ K26, 1'b0};
      for (int i = 0; i < 40; i++) ct2[i] = {$urandom, $urandom, $urandom, $urandom};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", 128'(bus.s_ready), 0);
      chk("rst_m_valid", 128'(bus.m_valid), 0);
      chk("rst_in_flight", 128'(in_flight), 0);
      chk("rst_err_bad_key", 128'(err_bad_key), 0);
      chk("rst_core_ct", core_ct, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_m_data", bus.m_data, 0);
      rst = 1'b0;
      idle(1'b1);
      chk("ready_after_rst", 128'(bus.s_ready), 1);
      wr_key(5, K5);
      wr_key(26, K26);
      wr_key(3, K3);
      nacc = 0;
      for (int i = 0; i < 27; i++) begin
         step(1'b1, vecs[i].ct, vecs[i].kidx, vecs[i].tag, 1'b1, '{tag: vecs[i].tag, err: vecs[i].exp_err, data: vecs[i].exp_data}, a);
         if (a) nacc++;
      end
      chk("stream_accepts", 128'(nacc), 27);
      chk("stream_in_flight", 128'(in_flight), 20);
      drain("stream_drain");
      chk("first_latency", 128'(first_mv_cyc - first_acc_cyc), 21);
      chk("err_sticky_set", 128'(err_bad_key), 1);
      nacc = 0;
      for (int c = 0; c < 45; c++) begin
         send(1'b1, ct2[nacc], 3, 8'(nacc), 1'b0, a);
         if (a) nacc++;
      end
      chk("credit_accepts", 128'(nacc), 32);
      chk("credit_s_ready", 128'(bus.s_ready), 0);
      chk("credit_in_flight", 128'(in_flight), 7);
      repeat (20) idle(1'b0);
      chk("full_in_flight", 128'(in_flight), 0);
      chk("full_s_ready", 128'(bus.s_ready), 0);
      chk("full_m_valid", 128'(bus.m_valid), 1);
      send(1'b1, ct2[nacc], 3, 8'(nacc), 1'b1, a);
      chk("pop_cycle_no_accept", 128'(a), 0);
      chk("ready_after_pop", 128'(bus.s_ready), 1);
      for (int c = 0; c < 100 && nacc < 40; c++) begin
         send(1'b1, ct2[nacc], 3, 8'(nacc), 1'b1, a);
         if (a) nacc++;
      end
      chk("credit_total", 128'(nacc), 40);
      drain("credit_drain");
      chk("err_sticky_hold", 128'(err_bad_key), 1);
      for (int i = 0; i < 14; i++) send(1'b1, ct2[i], 5, 8'(8'h80 + i), 1'b0, a);
      repeat (10) idle(1'b0);
      chk("pre_rst_in_flight", 128'(in_flight), 10);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_flight", 128'(in_flight), 0);
      chk("mid_rst_s_ready", 128'(bus.s_ready), 0);
      chk("mid_rst_m_valid", 128'(bus.m_valid), 0);
      sb.delete();
      keys = '{default: '0};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mv = 0;
      for (int i = 0; i < 25; i++) begin
         idle(1'b1);
         if (bus.m_valid) mv++;
      end
      chk("post_rst_no_beats", 128'(mv), 0);
      chk("post_rst_in_flight", 128'(in_flight), 0);
      chk("post_rst_err_clear", 128'(err_bad_key), 0);
      wr_key(5, K5);
      key_wr_en = 1'b1;
      key_wr_idx = 5;
      key_wr_data = K5B;
      step(1'b1, 128'h00112233445566778899aabbccddeeff, 5, 8'h51, 1'b1, '{tag: 8'h51, err: 1'b0, data: 128'h00112233445566778899aabbccddeeff ^ K5}, a);
      chk("rbw_accept", 128'(a), 1);
      step(1'b1, 128'h0f0e0d0c0b0a09080706050403020100, 5, 8'h52, 1'b1, '{tag: 8'h52, err: 1'b0, data: 128'h0f0e0d0c0b0a09080706050403020100 ^ K5B}, a);
      key_wr_en = 1'b1;
      key_wr_idx = 28;
      key_wr_data = K3;
      step(1'b1, 128'h1234, 26, 8'h53, 1'b1, '{tag: 8'h53, err: 1'b0, data: 128'h1234}, a);
      drain("rbw_drain");
      nacc = 0;
      for (int c = 0; c < 5000 && nacc < 500; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            key_wr_en = 1'b1;
            key_wr_idx = KW'($urandom_range(0, 31));
            key_wr_data = {$urandom, $urandom, $urandom, $urandom};
         end
         send(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, KW'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)), a);
         if (a) nacc++;
      end
      chk("rand_accepts", 128'(nacc), 500);
      drain("rand_drain");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end
endmodule
